// File: rtl/da_bit_serializer_if.sv
// Sample handshake and bit-slice output bundle between a sample source and the DA serializer.
// The master side feeds samples; the slave side (the serializer) drives the slice outputs.
interface da_bit_serializer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              sample_ready;
    logic [3:0]        lut_addr0;
    logic [3:0]        lut_addr1;
    logic [3:0]        lut_addr2;
    logic [3:0]        lut_addr3;
    logic [3:0]        lut_addr4;
    logic [3:0]        lut_addr5;
    logic [3:0]        lut_addr6;
    logic [3:0]        lut_addr7;
    logic              slice_valid;
    logic              sign_slice;
    logic              last_slice;
    logic              frame_done;

    modport master (
        output sample_in, sample_valid,
        input  sample_ready, lut_addr0, lut_addr1, lut_addr2, lut_addr3,
               lut_addr4, lut_addr5, lut_addr6, lut_addr7,
               slice_valid, sign_slice, last_slice, frame_done
    );

    modport slave (
        input  sample_in, sample_valid,
        output sample_ready, lut_addr0, lut_addr1, lut_addr2, lut_addr3,
               lut_addr4, lut_addr5, lut_addr6, lut_addr7,
               slice_valid, sign_slice, last_slice, frame_done
    );
endinterface

// File: rtl/da_bit_serializer.sv
// Distributed-arithmetic front end: a 32-tap sample delay line read out MSB-first as
// bit-slices, one 4-bit LUT address per group of 4 taps.
//
// state | meaning
// IDLE  | ready for a sample; accept shifts the delay line and loads the bit counter
// SHIFT | one bit-slice per cycle, counter from DATA_W-1 down to 0
// DONE  | single-cycle frame_done pulse, then back to IDLE
module da_bit_serializer #(
    parameter int DATA_W = 16
) (
    input logic                clk3,
    input logic                reset,
    da_bit_serializer_if.slave bus
);
    localparam int TAPS   = 32;
    localparam int GROUPS = TAPS / 4;
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tap_q [TAPS];
    logic              accept;
    logic [3:0]        addr [GROUPS];

    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sample_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                    cnt_d   = CNT_MAX;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The delay line only moves on accept, so it stays stable for the whole frame.
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                tap_q[i] <= '0;
            end
        end else if (accept) begin
            tap_q[0] <= bus.sample_in;
            for (int i = 1; i < TAPS; i++) begin
                tap_q[i] <= tap_q[i-1];
            end
        end
    end

    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            addr[g] = 4'b0000;
            if (state_q == SHIFT) begin
                for (int j = 0; j < 4; j++) begin
                    addr[g][j] = tap_q[4*g+j][cnt_q];
                end
            end
        end
    end

    assign bus.lut_addr0    = addr[0];
    assign bus.lut_addr1    = addr[1];
    assign bus.lut_addr2    = addr[2];
    assign bus.lut_addr3    = addr[3];
    assign bus.lut_addr4    = addr[4];
    assign bus.lut_addr5    = addr[5];
    assign bus.lut_addr6    = addr[6];
    assign bus.lut_addr7    = addr[7];
    assign bus.sample_ready = (state_q == IDLE);
    assign bus.slice_valid  = (state_q == SHIFT);
    assign bus.sign_slice   = (state_q == SHIFT) && (cnt_q == CNT_MAX);
    assign bus.last_slice   = (state_q == SHIFT) && (cnt_q == '0);
    assign bus.frame_done   = (state_q == DONE);
endmodule

// File: tb/tb_da_bit_serializer.sv
// Randomized bench for da_bit_serializer: a cycle-count frame model plus a DA accumulator
// built on the observed LUT addresses with all coefficients set to 1.
module tb_da_bit_serializer;
    localparam int DATA_W = 16;
    localparam int FRAME  = DATA_W + 2;

    logic clk3  = 1'b0;
    logic reset = 1'b0;

    da_bit_serializer_if #(.DATA_W(DATA_W)) bus ();

    da_bit_serializer #(.DATA_W(DATA_W)) dut (
        .clk3  (clk3),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk3 = ~clk3;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: delay-line contents and cycles elapsed since the last accept (0 = idle).
    logic [DATA_W-1:0] m_tap [32];
    int phase     = 0;
    int acc       = 0;
    int last_sign = -1;
    bit cont_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 32; m++) m_tap[m] = '0;
        phase = 0;
    endtask

    task automatic model_edge(input logic v, input logic [DATA_W-1:0] d);
        if (!reset) begin
            model_clear();
        end else if (phase == 0) begin
            if (v) begin
                for (int m = 31; m > 0; m--) m_tap[m] = m_tap[m-1];
                m_tap[0] = d;
                phase = 1;
            end
        end else if (phase == DATA_W + 1) begin
            phase = 0;
        end else begin
            phase++;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] obs_addr;
        logic [31:0] exp_addr;
        bit sv;
        int b;
        int pop;
        int dot;
        obs_addr = {bus.lut_addr7, bus.lut_addr6, bus.lut_addr5, bus.lut_addr4,
                    bus.lut_addr3, bus.lut_addr2, bus.lut_addr1, bus.lut_addr0};
        sv = (phase >= 1) && (phase <= DATA_W);
        b  = DATA_W - phase;
        exp_addr = '0;
        if (sv) begin
            for (int m = 0; m < 32; m++) exp_addr[m] = m_tap[m][b];
        end
        chk("ready", 32'(bus.sample_ready), 32'(phase == 0));
        chk("slice_valid", 32'(bus.slice_valid), 32'(sv));
        chk("sign_slice", 32'(bus.sign_slice), 32'(phase == 1));
        chk("last_slice", 32'(bus.last_slice), 32'(phase == DATA_W));
        chk("frame_done", 32'(bus.frame_done), 32'(phase == DATA_W + 1));
        chk("lut_addr", obs_addr, exp_addr);

        pop = $countones(obs_addr);
        if (bus.sign_slice) acc = -pop;
        else if (bus.slice_valid) acc = 2 * acc + pop;
        if (bus.frame_done && phase == DATA_W + 1) begin
            dot = 0;
            for (int m = 0; m < 32; m++) dot += int'($signed(m_tap[m]));
            chk("dot_product", 32'(acc), 32'(dot));
        end
        if (bus.sign_slice) begin
            if (cont_mode && last_sign >= 0) chk("accept_spacing", 32'(cyc - last_sign), 32'(FRAME));
            last_sign = cyc;
        end
    endtask

    task automatic step(input logic v, input logic [DATA_W-1:0] d);
        bus.sample_valid = v;
        bus.sample_in    = d;
        @(posedge clk3);
        cyc++;
        model_edge(v, d);
        #1;
        check_outputs();
    endtask

    task automatic load(input logic [DATA_W-1:0] d);
        bit taken;
        taken = 1'b0;
        for (int t = 0; t < 2 * FRAME && !taken; t++) begin
            taken = bus.sample_ready;
            step(1'b1, d);
        end
        if (!taken) chk("load_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int t = 0; t < n; t++) step(1'b0, '0);
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        model_clear();
        #3;
        check_outputs();
        idle_cycles(2);
        reset = 1'b1;

        // Single 0x8001 held valid: accepted on the first edge after release.
        for (int t = 0; t < FRAME + 1; t++) step(1'b1, 16'h8001);
        idle_cycles(FRAME);

        // Fill the whole delay line with k+1.
        for (int k = 0; k < 32; k++) load(16'(k + 1));
        idle_cycles(FRAME);

        // Reset during slice 7: outputs drop without a clock edge, frame is abandoned.
        load(16'hA5A5);
        idle_cycles(6);
        chk("pre_reset_phase", 32'(bus.slice_valid), 32'd1);
        reset = 1'b0;
        #1;
        model_clear();
        check_outputs();
        idle_cycles(2);
        reset = 1'b1;
        load(16'h0001);
        idle_cycles(FRAME);

        // Valid held high with changing data: only ready cycles accept.
        cont_mode = 1'b1;
        last_sign = -1;
        for (int t = 0; t < 6 * FRAME; t++) step(1'b1, 16'($urandom));
        cont_mode = 1'b0;
        idle_cycles(FRAME);

        load(16'hFFFF);
        idle_cycles(FRAME);

        for (int t = 0; t < 1500; t++) step(1'($urandom_range(0, 3) != 0), 16'($urandom));
        idle_cycles(FRAME);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
